// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: BTB plus 2-bit saturating counter table, bimodal or gshare indexed.
// Lookup is combinational from registered state (zero latency); training takes effect next cycle.
// Backpressure: none on lookup/update; stall only freezes speculative global-history updates.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   stall                  freezes speculative GHR shift on lookup
//   lookup_valid/_pc       IF-stage fetch PC
//   pred_hit/_taken/_target/_ghr   prediction and the history snapshot used to make it
//   update_*               resolved control-flow instruction from EX/MEM
//   stat_branches/_mispredicts     saturating event counters
module branch_predictor_bht #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 6,
  parameter int MODE     = 0,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                lookup_valid,
  input  logic [XLEN-1:0]     lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_is_cond,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic                update_mispredict,
  input  logic [GHR_BITS-1:0] update_ghr,
  output logic [CNT_BITS-1:0] stat_branches,
  output logic [CNT_BITS-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TLO = IDX + 2;

  logic                valid_q   [ENTRIES];
  logic                is_cond_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q     [ENTRIES];
  logic [XLEN-1:0]     target_q  [ENTRIES];
  logic [1:0]          ctr_q     [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;

  logic [IDX-1:0]      l_bidx, l_cidx, u_bidx, u_cidx;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                l_hit;

  // Shift one outcome into a history vector, oldest bit falls off the top.
  function automatic logic [GHR_BITS-1:0] hist_shift(input logic [GHR_BITS-1:0] h, input logic b);
    logic [GHR_BITS:0] tmp;
    tmp = {h, b};
    return tmp[GHR_BITS-1:0];
  endfunction

  // Index/tag extraction; upper PC bits beyond the tag are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, update_pc};

  assign l_bidx = lookup_pc[IDX+1:2];
  assign l_tag  = lookup_pc[TLO+TAG_BITS-1:TLO];
  assign u_bidx = update_pc[IDX+1:2];
  assign u_tag  = update_pc[TLO+TAG_BITS-1:TLO];

  // gshare folds the (zero-extended) history into the counter index only; BTB stays PC-indexed.
  assign l_cidx = (MODE != 0) ? (l_bidx ^ IDX'(ghr_q))      : l_bidx;
  assign u_cidx = (MODE != 0) ? (u_bidx ^ IDX'(update_ghr)) : u_bidx;

  // Lookup: purely from registered state, so a same-cycle update is not visible yet.
  assign l_hit       = valid_q[l_bidx] && (tag_q[l_bidx] == l_tag);
  assign pred_hit    = lookup_valid && l_hit;
  assign pred_taken  = pred_hit && (is_cond_q[l_bidx] ? ctr_q[l_cidx][1] : 1'b1);
  assign pred_target = pred_taken ? target_q[l_bidx] : (lookup_pc + XLEN'(4));
  assign pred_ghr    = ghr_q;

  // Valid bits, counters, history and statistics: reset-initialised state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      ghr_q            <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update_valid) begin
        if (update_is_cond) begin
          if (update_taken && ctr_q[u_cidx] != 2'b11)
            ctr_q[u_cidx] <= ctr_q[u_cidx] + 2'b01;
          else if (!update_taken && ctr_q[u_cidx] != 2'b00)
            ctr_q[u_cidx] <= ctr_q[u_cidx] - 2'b01;
        end
        if (update_taken)
          valid_q[u_bidx] <= 1'b1;
        if (stat_branches != '1)
          stat_branches <= stat_branches + 1'b1;
        if (update_mispredict && stat_mispredicts != '1)
          stat_mispredicts <= stat_mispredicts + 1'b1;
      end

      // A misprediction repairs history from the resolving instruction's snapshot;
      // otherwise a conditional BTB hit speculatively shifts in its own prediction.
      if (MODE != 0) begin
        if (update_valid && update_mispredict)
          ghr_q <= update_is_cond ? hist_shift(update_ghr, update_taken) : update_ghr;
        else if (pred_hit && is_cond_q[l_bidx] && !stall)
          ghr_q <= hist_shift(ghr_q, pred_taken);
      end
    end
  end

  // Tag/target payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clock) begin
    if (!reset && update_valid && update_taken) begin
      tag_q[u_bidx]     <= u_tag;
      target_q[u_bidx]  <= update_target;
      is_cond_q[u_bidx] <= update_is_cond;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Instance A: bimodal, 4-bit statistics.
  logic        a_stall, a_lv, a_hit, a_tk, a_uv, a_uc, a_ut, a_um;
  logic [31:0] a_lpc, a_tgt, a_upc, a_utgt;
  logic [5:0]  a_pghr, a_ughr;
  logic [3:0]  a_sb, a_sm;

  // Instance B: gshare, 6-bit history, 16-bit statistics.
  logic        b_stall, b_lv, b_hit, b_tk, b_uv, b_uc, b_ut, b_um;
  logic [31:0] b_lpc, b_tgt, b_upc, b_utgt;
  logic [5:0]  b_pghr, b_ughr;
  logic [15:0] b_sb, b_sm;

  branch_predictor_bht #(.MODE(0), .CNT_BITS(4)) u_a (
    .clock(clock), .reset(reset), .stall(a_stall),
    .lookup_valid(a_lv), .lookup_pc(a_lpc),
    .pred_hit(a_hit), .pred_taken(a_tk), .pred_target(a_tgt), .pred_ghr(a_pghr),
    .update_valid(a_uv), .update_pc(a_upc), .update_is_cond(a_uc), .update_taken(a_ut),
    .update_target(a_utgt), .update_mispredict(a_um), .update_ghr(a_ughr),
    .stat_branches(a_sb), .stat_mispredicts(a_sm)
  );

  branch_predictor_bht #(.MODE(1), .GHR_BITS(6), .CNT_BITS(16)) u_b (
    .clock(clock), .reset(reset), .stall(b_stall),
    .lookup_valid(b_lv), .lookup_pc(b_lpc),
    .pred_hit(b_hit), .pred_taken(b_tk), .pred_target(b_tgt), .pred_ghr(b_pghr),
    .update_valid(b_uv), .update_pc(b_upc), .update_is_cond(b_uc), .update_taken(b_ut),
    .update_target(b_utgt), .update_mispredict(b_um), .update_ghr(b_ughr),
    .stat_branches(b_sb), .stat_mispredicts(b_sm)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_upd(input logic [31:0] pc, input logic c, input logic t,
                       input logic [31:0] tg, input logic m);
    a_uv = 1'b1; a_upc = pc; a_uc = c; a_ut = t; a_utgt = tg; a_um = m;
  endtask

  task automatic b_upd(input logic [31:0] pc, input logic c, input logic t,
                       input logic [31:0] tg, input logic m, input logic [5:0] g);
    b_uv = 1'b1; b_upc = pc; b_uc = c; b_ut = t; b_utgt = tg; b_um = m; b_ughr = g;
  endtask

  logic       pt;
  logic [5:0] pg;
  logic       act;
  int         late_mis;

  initial begin
    a_stall = 0; a_lv = 0; a_lpc = 0; a_uv = 0; a_upc = 0; a_uc = 0; a_ut = 0; a_utgt = 0; a_um = 0; a_ughr = 0;
    b_stall = 0; b_lv = 0; b_lpc = 0; b_uv = 0; b_upc = 0; b_uc = 0; b_ut = 0; b_utgt = 0; b_um = 0; b_ughr = 0;
    late_mis = 0;

    reset = 1'b1; step(); reset = 1'b0;

    // Reset state
    a_lv = 1; a_lpc = 32'h100; b_lv = 1; b_lpc = 32'h300; #1;
    chk("rst_hit", a_hit, 0); chk("rst_taken", a_tk, 0); chk("rst_target", a_tgt, 32'h104);
    chk("rst_ghr", a_pghr, 0); chk("rst_sb", a_sb, 0); chk("rst_sm", a_sm, 0);
    chk("rst_b_hit", b_hit, 0); chk("rst_b_ghr", b_pghr, 0);

    // First training: same-cycle lookup sees old state
    a_upd(32'h100, 1, 1, 32'h80, 1); #1;
    chk("rdw_hit", a_hit, 0); chk("rdw_taken", a_tk, 0);
    step(); a_uv = 0; #1;
    chk("train1_hit", a_hit, 1); chk("train1_taken", a_tk, 1); chk("train1_target", a_tgt, 32'h80);
    chk("train1_sb", a_sb, 1); chk("train1_sm", a_sm, 1);
    a_lv = 0; #1;
    chk("nolookup_hit", a_hit, 0); chk("nolookup_taken", a_tk, 0);
    a_lv = 1;

    // Counter saturation: 10 -> 11 (x4) -> 10
    for (int i = 0; i < 4; i++) begin a_upd(32'h100, 1, 1, 32'h80, 0); step(); end
    a_upd(32'h100, 1, 0, 32'h0, 0); step(); a_uv = 0; #1;
    chk("sat_hi_taken", a_tk, 1); chk("sat_hi_hit", a_hit, 1);
    // 10 -> 01 -> 00
    for (int i = 0; i < 2; i++) begin a_upd(32'h100, 1, 0, 32'h0, 0); step(); end
    a_uv = 0; #1;
    chk("nt_taken", a_tk, 0); chk("nt_hit_kept", a_hit, 1); chk("nt_target", a_tgt, 32'h104);
    // stays 00
    for (int i = 0; i < 5; i++) begin a_upd(32'h100, 1, 0, 32'h0, 0); step(); end
    a_upd(32'h100, 1, 1, 32'h80, 0); step(); a_uv = 0; #1;
    chk("underflow_taken", a_tk, 0);
    a_upd(32'h100, 1, 1, 32'h80, 0); step(); a_uv = 0; #1;
    chk("recover_taken", a_tk, 1); chk("sb_15", a_sb, 4'hF); chk("sm_1", a_sm, 1);

    // JAL overwrites same direct-mapped slot
    a_upd(32'h200, 0, 1, 32'h400, 1); step(); a_uv = 0;
    a_lpc = 32'h200; #1;
    chk("jal_hit", a_hit, 1); chk("jal_taken", a_tk, 1); chk("jal_target", a_tgt, 32'h400);
    chk("jal_ghr", a_pghr, 0); chk("sb_sat", a_sb, 4'hF); chk("sm_2", a_sm, 2);
    a_lpc = 32'h100; #1;
    chk("evicted_hit", a_hit, 0); chk("evicted_taken", a_tk, 0);

    // Statistic saturation: 19 mispredicting updates in total
    for (int i = 0; i < 13; i++) begin a_upd(32'h600, 1, 1, 32'h700, 1); step(); end
    a_uv = 0; #1;
    chk("sm_15", a_sm, 4'hF);
    for (int i = 0; i < 6; i++) begin a_upd(32'h600, 1, 1, 32'h700, 1); step(); end
    a_uv = 0; #1;
    chk("sm_sat", a_sm, 4'hF); chk("sb_sat2", a_sb, 4'hF);

    // Reset mid-train clears everything, including the in-flight update
    a_upd(32'h600, 1, 1, 32'h700, 1); reset = 1'b1; step(); reset = 1'b0; a_uv = 0;
    a_lpc = 32'h600; #1;
    chk("mid_rst_hit", a_hit, 0); chk("mid_rst_target", a_tgt, 32'h604);
    chk("mid_rst_sb", a_sb, 0); chk("mid_rst_sm", a_sm, 0);
    a_lpc = 32'h200; #1;
    chk("mid_rst_hit_jal", a_hit, 0);
    // Counter back to 01: T then N leaves it predicting not-taken
    a_upd(32'h600, 1, 1, 32'h700, 0); step();
    a_upd(32'h600, 1, 0, 32'h0, 0); step(); a_uv = 0;
    a_lpc = 32'h600; #1;
    chk("mid_rst_ctr_hit", a_hit, 1); chk("mid_rst_ctr_taken", a_tk, 0);

    // gshare: alternating T/N branch at 0x300
    b_lpc = 32'h300; b_lv = 0;
    for (int it = 0; it < 30; it++) begin
      b_lv = 1; #1;
      pt = b_tk; pg = b_pghr; act = (it % 2 == 0);
      step(); b_lv = 0;
      b_upd(32'h300, 1, act, 32'h380, pt != act, pg);
      if (it >= 20 && pt != act) late_mis++;
      step(); b_uv = 0;
    end
    #1;
    chk("gs_total_mis", b_sm, 4); chk("gs_late_mis", late_mis, 0);
    chk("gs_branches", b_sb, 30); chk("gs_ghr", b_pghr, 6'b101010);

    // Speculative shift on a conditional hit
    b_lv = 1; #1;
    chk("gs_spec_taken", b_tk, 1);
    step(); b_lv = 0; #1;
    chk("gs_spec_ghr", b_pghr, 6'b010101);

    // Mispredict repair beats a same-cycle speculative shift
    b_lv = 1; b_upd(32'h300, 1, 1, 32'h380, 1, 6'b101010); #1;
    chk("gs_inj_hit", b_hit, 1);
    step(); b_uv = 0; b_lv = 0; #1;
    chk("gs_inj_ghr", b_pghr, 6'b010101);

    // Stall freezes speculation
    b_lv = 1; b_stall = 1; #1;
    chk("gs_stall_hit", b_hit, 1); chk("gs_stall_taken", b_tk, 0);
    step(); b_stall = 0; b_lv = 0; #1;
    chk("gs_stall_ghr", b_pghr, 6'b010101);
    b_lv = 1; step(); b_lv = 0; #1;
    chk("gs_unstall_ghr", b_pghr, 6'b101010);
    chk("gs_nolookup_hit", b_hit, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
